// File: rtl/mitssdd_pkg.sv
// Shared constants for the mitssdd hex display tile: segment table,
// pin field positions and the fixed bidirectional output-enable mask.
package mitssdd_pkg;

    // Segment patterns {g,f,e,d,c,b,a}; entry 0 sits in the low bits.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // ui_in fields
    localparam int UI_DIGIT_LSB = 0;
    localparam int UI_SRC_BIT   = 4;
    localparam int UI_EN_BIT    = 5;
    localparam int UI_DIR_BIT   = 6;
    localparam int UI_DP_BIT    = 7;

    // uio_in fields
    localparam int UIO_FAST_BIT = 0;
    localparam int UIO_CLR_BIT  = 1;

    // Upper nibble of uio drives the counter value, lower nibble is input.
    localparam logic [7:0] OE_MASK = 8'hF0;

endpackage

// File: rtl/mitssdd_hex_display_hex_to_7seg.sv
// Combinational hex digit to common-cathode segment decoder.
module hex_to_7seg
    import mitssdd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[digit_i];

endmodule

// File: rtl/mitssdd_hex_display.sv
// TinyTapeout tile: shows a hex digit on a 7-segment display, taken either
// from the input pins or from a 4-bit up/down counter with a prescaled tick.
module mitssdd_hex_display
    import mitssdd_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int PRESC_W  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);

    logic               rst;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         uo_q, uo_d;
    logic [3:0]         digit_s;
    logic [6:0]         seg_s;
    logic               tick_s;
    logic               clr_s;
    logic               cnt_en_s;
    logic               dir_s;
    logic               fast_s;
    logic               unused_s;

    assign rst      = ~rst_n;
    assign clr_s    = uio_in[UIO_CLR_BIT];
    assign fast_s   = uio_in[UIO_FAST_BIT];
    assign cnt_en_s = ui_in[UI_EN_BIT];
    assign dir_s    = ui_in[UI_DIR_BIT];
    assign unused_s = &{1'b0, uio_in[7:2]};

    // Tick fires every clock in fast mode, else on the last prescaler phase.
    assign tick_s = fast_s | (presc_q == PRESC_TOP);

    // The display shows the counter value held before this edge's update.
    assign digit_s = ui_in[UI_SRC_BIT] ? cnt_q : ui_in[UI_DIGIT_LSB +: 4];

    hex_to_7seg u_dec (
        .digit_i (digit_s),
        .seg_o   (seg_s)
    );

    // Next-state for prescaler and counter: clear first, then enabled step.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (clr_s) begin
            presc_d = {PRESC_W{1'b0}};
            cnt_d   = 4'h0;
        end else if (ena && cnt_en_s) begin
            if (presc_q == PRESC_TOP) begin
                presc_d = {PRESC_W{1'b0}};
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
            if (tick_s) begin
                if (dir_s) begin
                    cnt_d = cnt_q + 4'h1;
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            presc_d = presc_q;
            cnt_d   = cnt_q;
        end
    end

    // Display word: decimal point on top of the decoded segments.
    always_comb begin
        uo_d = {ui_in[UI_DP_BIT], seg_s};
    end

    // State and output registers, cleared asynchronously by the tile reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= {PRESC_W{1'b0}};
            cnt_q   <= 4'h0;
            uo_q    <= 8'h00;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {cnt_q, 4'h0};
    assign uio_oe  = OE_MASK;

endmodule

// File: tb/tb_mitssdd_hex_display.sv
// Scoreboard bench for mitssdd_hex_display: stimulus pushes expected outputs
// from a behavioural model, a monitor pops and compares after each edge.
module tb_mitssdd_hex_display;

    localparam int TD = 4;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    int   m_ph   = 0;

    mitssdd_hex_display #(.TICK_DIV(TD), .PRESC_W(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, req);
        end
    endtask

    // Model of one clock edge: predict outputs, then advance counter state.
    task automatic drive_push(input logic [7:0] ui, input logic [7:0] uio,
                              input logic en_v, input string nm);
        exp_t e;
        int   digit;
        bit   tick;
        ui_in  = ui;
        uio_in = uio;
        ena    = en_v;
        digit  = ui[4] ? m_cnt : int'(ui[3:0]);
        e.uo   = {ui[7], SEG_TBL[digit]};
        if (uio[1]) begin
            m_cnt = 0;
            m_ph  = 0;
        end else if (en_v && ui[5]) begin
            tick = uio[0] || (m_ph == TD - 1);
            m_ph = (m_ph + 1) % TD;
            if (tick) m_cnt = ui[6] ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
        end
        e.uio  = 8'(m_cnt << 4);
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic [7:0] ui, input logic [7:0] uio,
                        input logic en_v, input string nm);
        @(negedge clk);
        drive_push(ui, uio, en_v, nm);
    endtask

    // Monitor: after every rising edge compare the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check8({e.name, "_uo"}, uo_out, e.uo);
                check8({e.name, "_uio"}, uio_out, e.uio);
                check8({e.name, "_oe"}, uio_oe, 8'hF0);
            end
        end
    end

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check8("rst_uo", uo_out, 8'h00);
        check8("rst_uio", uio_out, 8'h00);
        check8("rst_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        step(8'h00, 8'h00, 1'b0, "release");

        // Direct decode of every digit, then decimal point with 8.
        for (int i = 0; i < 16; i++) step(8'(i), 8'h00, 1'b1, "direct");
        step(8'h88, 8'h00, 1'b1, "direct_dp8");

        // Fast count up through a full wrap.
        step(8'h70, 8'h02, 1'b1, "clr");
        for (int i = 0; i < 16; i++) step(8'h70, 8'h01, 1'b1, "fast_up");

        // Down wrap from 0, then clear with enable still high.
        step(8'h30, 8'h01, 1'b1, "down_wrap");
        step(8'h30, 8'h01, 1'b1, "down");
        step(8'hF0, 8'h03, 1'b1, "clr_en");

        // Slow mode: one step per TD clocks, frozen while ena is low.
        for (int i = 0; i < 10; i++) step(8'h70, 8'h00, 1'b1, "slow");
        for (int i = 0; i < 3; i++)  step(8'h70, 8'h00, 1'b0, "slow_hold");
        for (int i = 0; i < 9; i++)  step(8'hF0, 8'h00, 1'b1, "slow_resume");

        // Async reset between edges while fast counting.
        for (int i = 0; i < 5; i++) step(8'h70, 8'h01, 1'b1, "pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check8("midrst_uo", uo_out, 8'h00);
        check8("midrst_uio", uio_out, 8'h00);
        #1 rst_n = 1'b1;
        m_cnt = 0;
        m_ph  = 0;
        drive_push(8'h70, 8'h01, 1'b1, "post_rst");
        for (int i = 0; i < 3; i++) step(8'h70, 8'h01, 1'b1, "post_rst");

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r_ui;
            logic [7:0] r_uio;
            logic       r_en;
            r_ui  = 8'($urandom);
            r_uio = {6'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom)};
            r_en  = ($urandom_range(0, 3) != 0);
            step(r_ui, r_uio, r_en, "rand");
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
